// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-master ROM arbiter.
package rom_arb_pkg;

  localparam int unsigned M_IFETCH  = 0;
  localparam int unsigned M_DATA    = 1;
  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);

  // Read issued last cycle and which master owns its returning data
  typedef struct packed {
    logic valid;
    logic owner;
  } inflight_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO; head data and count come straight from registers.
module rsp_fifo2
  import rom_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             not_empty,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [RSP_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic             pop_ok;
  logic             push_ok;

  assign not_empty = (count != '0);
  assign pop_ok    = pop && not_empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign push_ok   = push && ((count != CNT_W'(RSP_DEPTH)) || pop_ok);
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one rom (write port + registered read port)
// between an instruction-fetch master and a data master.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [RAM_WIDTH-1:0]  m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [RAM_WIDTH-1:0]  m0_rsp_data,
  input  logic                  m0_rsp_ready,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [RAM_WIDTH-1:0]  m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [RAM_WIDTH-1:0]  m1_rsp_data,
  input  logic                  m1_rsp_ready,

  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [RAM_WIDTH-1:0]  mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [RAM_WIDTH-1:0]  mem_rd_data
);

  localparam int unsigned OCC_W = CNT_W + 1;

  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            rsp_ready;
  logic [1:0]            not_empty;
  logic [1:0]            pop;
  logic [1:0]            push;
  logic [1:0]            elig;
  logic [1:0]            rdy;
  logic [1:0]            grant;
  logic [CNT_W-1:0]      cnt  [2];
  logic [OCC_W-1:0]      occ  [2];

  logic                  any_grant;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]  sel_wdata;

  inflight_t             infl_q;
  inflight_t             infl_d;
  logic                  last_q;
  logic                  last_d;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign req_we    = {m1_req_we,    m0_req_we};
  assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};
  assign pop       = not_empty & rsp_ready;
  assign push[0]   = infl_q.valid && (infl_q.owner == 1'(M_IFETCH));
  assign push[1]   = infl_q.valid && (infl_q.owner == 1'(M_DATA));

  // Eligibility counts buffered + in-flight reads minus the one leaving now
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      occ[n]  = OCC_W'(cnt[n]) + OCC_W'(push[n]) - OCC_W'(pop[n]);
      elig[n] = rst_n && (req_we[n] || (occ[n] < OCC_W'(RSP_DEPTH)));
    end
  end

  // The master that did not win last holds priority; ready ignores own valid
  always_comb begin
    rdy[0] = elig[0] && !(req_valid[1] && elig[1] && (last_q == 1'(M_IFETCH)));
    rdy[1] = elig[1] && !(req_valid[0] && elig[0] && (last_q == 1'(M_DATA)));
  end

  assign grant        = req_valid & rdy;
  assign m0_req_ready = rdy[0];
  assign m1_req_ready = rdy[1];

  assign any_grant = |grant;
  assign sel       = grant[1];
  assign sel_we    = sel ? m1_req_we    : m0_req_we;
  assign sel_addr  = sel ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = sel ? m1_req_wdata : m0_req_wdata;

  // rom port muxing; idle address/data are forced to zero
  always_comb begin
    mem_wr_en   = any_grant && sel_we;
    mem_rd_en   = any_grant && !sel_we;
    mem_wr_addr = mem_wr_en ? sel_addr  : '0;
    mem_wr_data = mem_wr_en ? sel_wdata : '0;
    mem_rd_addr = mem_rd_en ? sel_addr  : '0;
  end

  always_comb begin
    infl_d = '0;
    last_d = last_q;
    if (any_grant) begin
      last_d       = sel;
      infl_d.valid = !sel_we;
      infl_d.owner = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= '0;
      last_q <= 1'(M_DATA);
    end else begin
      infl_q <= infl_d;
      last_q <= last_d;
    end
  end

  rsp_fifo2 #(.WIDTH(RAM_WIDTH)) u_fifo_m0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[0]),
    .push_data (mem_rd_data),
    .pop       (pop[0]),
    .count     (cnt[0]),
    .not_empty (not_empty[0]),
    .head_data (m0_rsp_data)
  );

  rsp_fifo2 #(.WIDTH(RAM_WIDTH)) u_fifo_m1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[1]),
    .push_data (mem_rd_data),
    .pop       (pop[1]),
    .count     (cnt[1]),
    .not_empty (not_empty[1]),
    .head_data (m1_rsp_data)
  );

  assign m0_rsp_valid = not_empty[0];
  assign m1_rsp_valid = not_empty[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: behavioural rom, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_rom_arbiter;

  localparam int unsigned RW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req_valid = 0, m0_req_we = 0, m0_rsp_ready = 0;
  logic          m1_req_valid = 0, m1_req_we = 0, m1_rsp_ready = 0;
  logic [AW-1:0] m0_req_addr = '0, m1_req_addr = '0;
  logic [RW-1:0] m0_req_wdata = '0, m1_req_wdata = '0;
  logic          m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [RW-1:0] m0_rsp_data, m1_rsp_data;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [RW-1:0] mem_wr_data, mem_rd_data;

  logic [RW-1:0] rom_mem [DEPTH];
  logic [RW-1:0] ref_mem [DEPTH];

  // reference model: per-master expected responses with the cycle they appear
  logic [RW-1:0] exp_data [2][16];
  int            exp_due  [2][16];
  int            hd [2];
  int            tl [2];
  int            last;
  int            cyc;
  int            hs [2];
  int            rh [2];
  int            checks = 0;
  int            errors = 0;
  int            base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rom_mem[mem_rd_addr];
    if (mem_wr_en) rom_mem[mem_wr_addr] = mem_wr_data;
  end

  rom_arbiter #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_we    (m0_req_we),
    .m0_req_addr  (m0_req_addr),
    .m0_req_wdata (m0_req_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_data  (m0_rsp_data),
    .m0_rsp_ready (m0_rsp_ready),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_we    (m1_req_we),
    .m1_req_addr  (m1_req_addr),
    .m1_req_wdata (m1_req_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_data  (m1_rsp_data),
    .m1_rsp_ready (m1_rsp_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data)
  );

  function automatic logic [RW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance
  task automatic step();
    logic          v [2], we [2], rr [2], ev [2], pp [2], el [2], rdy [2], g [2];
    logic [AW-1:0] ad [2];
    logic [RW-1:0] wd [2];
    logic [RW-1:0] got_data [2];
    logic          got_rdy [2], got_rv [2];
    logic          any, e_wr, e_rd;
    int            s;
    @(negedge clk);
    v[0] = m0_req_valid; we[0] = m0_req_we; ad[0] = m0_req_addr; wd[0] = m0_req_wdata; rr[0] = m0_rsp_ready;
    v[1] = m1_req_valid; we[1] = m1_req_we; ad[1] = m1_req_addr; wd[1] = m1_req_wdata; rr[1] = m1_rsp_ready;
    got_rdy[0] = m0_req_ready; got_rv[0] = m0_rsp_valid; got_data[0] = m0_rsp_data;
    got_rdy[1] = m1_req_ready; got_rv[1] = m1_rsp_valid; got_data[1] = m1_rsp_data;
    for (int n = 0; n < 2; n++) begin
      ev[n] = rst_n && (tl[n] > hd[n]) && (exp_due[n][hd[n] & 15] <= cyc);
      pp[n] = ev[n] && rr[n];
      el[n] = rst_n && (we[n] || ((tl[n] - hd[n] - int'(pp[n])) < 2));
    end
    for (int n = 0; n < 2; n++) begin
      rdy[n] = el[n] && !(v[1-n] && el[1-n] && (last == n));
      g[n]   = v[n] && rdy[n];
    end
    any  = g[0] || g[1];
    s    = g[1] ? 1 : 0;
    e_wr = any && we[s];
    e_rd = any && !we[s];
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("m%0d_req_ready@%0d", n, cyc), got_rdy[n], rdy[n]);
      chk($sformatf("m%0d_rsp_valid@%0d", n, cyc), got_rv[n], ev[n]);
      if (ev[n]) chk($sformatf("m%0d_rsp_data@%0d", n, cyc), got_data[n], exp_data[n][hd[n] & 15]);
      else if (!rst_n) chk($sformatf("m%0d_rsp_data_rst", n), got_data[n], 0);
      if (got_rdy[n] && v[n]) hs[n]++;
      if (got_rv[n] && rr[n]) rh[n]++;
    end
    chk($sformatf("mem_wr_en@%0d", cyc), mem_wr_en, e_wr);
    chk($sformatf("mem_rd_en@%0d", cyc), mem_rd_en, e_rd);
    chk($sformatf("mem_wr_addr@%0d", cyc), mem_wr_addr, e_wr ? ad[s] : '0);
    chk($sformatf("mem_wr_data@%0d", cyc), mem_wr_data, e_wr ? wd[s] : '0);
    chk($sformatf("mem_rd_addr@%0d", cyc), mem_rd_addr, e_rd ? ad[s] : '0);
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin hd[n] = 0; tl[n] = 0; end
      last = 1;
    end else begin
      for (int n = 0; n < 2; n++) if (pp[n]) hd[n]++;
      if (any) begin
        last = s;
        if (we[s]) ref_mem[ad[s]] = wd[s];
        else begin
          exp_data[s][tl[s] & 15] = ref_mem[ad[s]];
          exp_due[s][tl[s] & 15]  = cyc + 2;
          tl[s]++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req_valid = 0; m1_req_valid = 0; m0_req_we = 0; m1_req_we = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    hd[0] = 0; hd[1] = 0; tl[0] = 0; tl[1] = 0; hs[0] = 0; hs[1] = 0; rh[0] = 0; rh[1] = 0;
    last = 1; cyc = 0;

    // reset with both masters requesting
    m0_req_valid = 1; m1_req_valid = 1;
    repeat (3) step();
    chk("rst_m0_req_ready", m0_req_ready, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    idle_all();
    rst_n = 1;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    step();

    // preload 0xDEADBEEF at 0x005, then a single m0 read
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'h005; m1_req_wdata = 32'hDEAD_BEEF;
    step();
    idle_all();
    m0_req_valid = 1; m0_req_addr = 10'h005;
    #1;
    chk("single_rd_en_T", mem_rd_en, 1);
    step();
    idle_all();
    chk("single_rsp_T1", m0_rsp_valid, 0);
    step();
    chk("single_rsp_valid_T2", m0_rsp_valid, 1);
    chk("single_rsp_data_T2", m0_rsp_data, 32'hDEAD_BEEF);
    step();

    // round-robin with both masters reading continuously
    m0_req_valid = 1; m1_req_valid = 1;
    repeat (4) begin
      m0_req_addr = AW'($urandom); m1_req_addr = AW'($urandom);
      step();
    end
    base = rh[0];
    repeat (10) begin
      m0_req_addr = AW'($urandom); m1_req_addr = AW'($urandom);
      step();
    end
    chk("rr_m0_rsp_per_10", rh[0] - base, 5);
    idle_all();
    repeat (4) step();

    // backpressure on m1
    m1_rsp_ready = 0;
    m1_req_valid = 1; m1_req_addr = 10'h021;
    base = hs[1];
    repeat (6) step();
    chk("bp_reads_accepted", hs[1] - base, 2);
    chk("bp_req_ready_low", m1_req_ready, 0);
    m1_req_we = 1; m1_req_addr = 10'h022; m1_req_wdata = 32'hCAFE_0001;
    #1;
    chk("bp_write_ready", m1_req_ready, 1);
    step();
    idle_all();
    m1_rsp_ready = 1;
    base = rh[1];
    repeat (3) step();
    chk("bp_drain_count", rh[1] - base, 2);
    m1_req_valid = 1; m1_req_addr = 10'h022;
    base = hs[1];
    repeat (3) step();
    chk("bp_reads_resume", hs[1] - base, 3);
    idle_all();
    repeat (4) step();

    // write at T, read of the same address at T+1
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'h3FF; m1_req_wdata = 32'h1234_5678;
    step();
    idle_all();
    m0_req_valid = 1; m0_req_addr = 10'h3FF;
    step();
    idle_all();
    step();
    chk("wr_then_rd_valid", m0_rsp_valid, 1);
    chk("wr_then_rd_data", m0_rsp_data, 32'h1234_5678);
    step();

    // fill m0 FIFO, then push and pop together at full
    m0_rsp_ready = 0;
    m0_req_valid = 1;
    repeat (4) begin m0_req_addr = AW'($urandom); step(); end
    m0_rsp_ready = 1;
    repeat (2) begin m0_req_addr = AW'($urandom); step(); end
    base = rh[0];
    repeat (8) begin m0_req_addr = AW'($urandom); step(); end
    chk("full_pushpop_stream", rh[0] - base, 8);
    idle_all();
    repeat (4) step();

    // randomized traffic over a small address window to provoke hazards
    repeat (400) begin
      m0_req_valid = ($urandom % 4) != 0; m0_req_we = ($urandom % 4) == 0;
      m0_req_addr = AW'($urandom % 16); m0_req_wdata = $urandom;
      m1_req_valid = ($urandom % 4) != 0; m1_req_we = ($urandom % 3) == 0;
      m1_req_addr = AW'($urandom % 16); m1_req_wdata = $urandom;
      m0_rsp_ready = ($urandom % 3) != 0; m1_rsp_ready = ($urandom % 3) != 0;
      step();
    end

    // reset mid-traffic with a read in flight
    idle_all();
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    repeat (4) step();
    m0_req_valid = 1; m0_req_addr = 10'h005;
    step();
    rst_n = 0;
    #1;
    chk("midrst_m0_rsp_valid", m0_rsp_valid, 0);
    chk("midrst_m1_req_ready", m1_req_ready, 0);
    step();
    step();
    idle_all();
    rst_n = 1;
    repeat (3) step();
    chk("post_rst_no_rsp", m0_rsp_valid, 0);
    m0_req_valid = 1; m1_req_valid = 1;
    #1;
    chk("post_rst_conflict_m0", m0_req_ready, 1);
    chk("post_rst_conflict_m1", m1_req_ready, 0);
    repeat (6) step();
    idle_all();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares one `rom` instance (separate write and read ports, registered read data) between two requesters: master 0 (instruction fetch) and master 1 (data load/store and boot loader). Each master issues read or write requests over a valid/ready handshake and receives read data over a valid/ready response channel. Grants are round-robin, one grant per cycle. Per-master response buffering sustains one read per cycle under backpressure without losing data.

## Interface
- `RAM_WIDTH`, 32, data width; must match the attached `rom`.
- `ADDR_WIDTH`, 10, address width; must match the attached `rom`.
- `clk`  in  1  single clock; drives every register in the block and the attached `rom` (`wr_clk` and `rd_clk` are both tied to `clk`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `mN_req_valid`  in  1  request valid from master N (N = 0, 1).
- `mN_req_ready`  out  1  request accepted when high together with valid.
- `mN_req_we`  in  1  1 = write, 0 = read.
- `mN_req_addr`  in  ADDR_WIDTH  word address.
- `mN_req_wdata`  in  RAM_WIDTH  write data.
- `mN_rsp_valid`  out  1  read data available.
- `mN_rsp_data`  out  RAM_WIDTH  read data, in request order.
- `mN_rsp_ready`  in  1  master consumes the response.
- `mem_wr_en`, `mem_wr_addr`, `mem_wr_data`  out  1/ADDR_WIDTH/RAM_WIDTH  to `rom` write port.
- `mem_rd_en`, `mem_rd_addr`  out  1/ADDR_WIDTH  to `rom` read port.
- `mem_rd_data`  in  RAM_WIDTH  from `rom`; valid the cycle after `mem_rd_en`.

## Operation
- **Eligibility.** Master N is eligible when `mN_req_we` = 1, or when `cnt_N + inflight_N - pop_N < 2`.
  - `cnt_N` is the occupancy of master N's 2-entry response FIFO.
  - `inflight_N` means a read for master N was issued in the previous cycle.
  - `pop_N` is `mN_rsp_valid & mN_rsp_ready`.
- **Arbitration.** Round-robin with pointer `last` (reset value 1, so master 0 wins the first conflict).
  - If both masters are valid and eligible, grant the master ≠ `last`.
  - Otherwise grant whichever single master is valid and eligible.
  - `last` updates to the granted master on every grant.
- **Ready rule.** `mN_req_ready` = eligible_N AND NOT (other master valid, eligible, and holding priority).
  - It never depends on `mN_req_valid`.
  - At most one master is granted per cycle.
- **Write grant.** `mem_wr_en` = 1 with that master's addr/data, in the same cycle, combinationally. There is no response for writes.
- **Read grant.** `mem_rd_en` = 1 with that master's addr, in the same cycle, combinationally. `inflight` and its owner ID are registered.
  - The next cycle, `mem_rd_data` is pushed into the owner's FIFO.
- **Idle outputs.** `mem_wr_en` = `mem_rd_en` = 0 when there is no grant. Address/data outputs are 0 when not enabled.
- **Ordering.**
  - Responses per master are returned in request order.
  - A write granted at cycle T is visible to a read granted at T+1 or later.
- **Simultaneous push and pop** on a FIFO are legal, including at count 2, because the eligibility rule already counts the pop.
- **Reset, including mid-operation.**
  - FIFOs are emptied, `inflight` is cleared, `last` = 1, and all outputs are 0.
  - Data of in-flight reads is discarded.

## Timing
- Read latency: request handshake at cycle T, `mem_rd_en` at T, data captured at the end of T+1, `mN_rsp_valid` = 1 at T+2.
- Throughput: one access per cycle total. A single master holding `rsp_ready` = 1 gets one read per cycle.
- Backpressure: with `rsp_ready` = 0, a master gets at most 2 reads accepted before its `req_ready` falls for reads. Writes remain accepted.
- `rsp_valid`/`rsp_data` come from FIFO registers only, with no combinational path from `mem_rd_data`.
- Combinational paths exist from `req_*` to `mem_*`, and from `rsp_ready` to `req_ready`.

## Structure
- Package `rom_arb_pkg`:
  - master ID constants `M_IFETCH` = 0, `M_DATA` = 1
  - `RSP_DEPTH` = 2
  - typedef for the in-flight tag {valid, owner}
- Sub-module `rsp_fifo2`: 2-entry FIFO (push, pop, count, data), instantiated once per master.
- Top level contains the arbiter, the ready logic, the in-flight register and the `rom` port muxing.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-traffic with a read in flight. Required: all outputs 0, no `rsp_valid` after release, and the first conflict is won by master 0.
- **Single read.** m0 reads addr 0x005 after a preload of 0xDEADBEEF. Required: `mem_rd_en` at T, `m0_rsp_valid` at T+2 with data 0xDEADBEEF.
- **Round-robin.** Both masters hold valid reads continuously with `rsp_ready` = 1. Required: grants alternate m0, m1, m0, ...; each master receives 1 response per 2 cycles, in order.
- **Backpressure.** m1 issues 4 reads with `m1_rsp_ready` = 0. Required: only 2 are accepted and `m1_req_ready` = 0 afterwards. An m1 write is still accepted. Raising `rsp_ready` drains 2 responses in order, then reads resume.
- **Write-then-read.** m1 writes 0x12345678 to 0x3FF at T, and m0 reads 0x3FF at T+1. Required: m0 response = 0x12345678.
- **Simultaneous push/pop at full.** m0's FIFO count is 2 with `rsp_ready` = 1 and a read arriving. Required: no overflow, no lost or duplicated data, and a continuous one-per-cycle response stream.
